// File: rtl/vx_cache_evict_buf.sv
// Writeback eviction buffer: captures dirty evicted lines into a small FIFO,
// issues them as memory write requests, and answers pending-writeback lookups.
module vx_cache_evict_buf #(
  parameter int unsigned LINE_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          evict_valid,
  input  logic [ADDR_WIDTH-1:0]         evict_addr,
  input  logic [LINE_SIZE*8-1:0]        evict_data,
  input  logic [LINE_SIZE-1:0]          evict_byteen,
  output logic                          evict_ready,
  output logic                          mem_req_valid,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [LINE_SIZE*8-1:0]        mem_req_data,
  output logic [LINE_SIZE-1:0]          mem_req_byteen,
  input  logic                          mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]         lookup_addr,
  output logic                          lookup_hit,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned DATA_W = LINE_SIZE * 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
  logic [DATA_W-1:0]     data_q   [DEPTH];
  logic [LINE_SIZE-1:0]  byteen_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_fire, push_store, pop_fire;

  assign evict_ready   = (count_q != CNT_W'(DEPTH));
  assign mem_req_valid = (count_q != CNT_W'(0));
  assign count         = count_q;

  assign push_fire  = evict_valid && evict_ready;
  // Clean lines complete the handshake but are never stored.
  assign push_store = push_fire && (|evict_byteen);
  assign pop_fire   = mem_req_valid && mem_req_ready;

  assign mem_req_addr   = addr_q[rd_ptr_q];
  assign mem_req_data   = data_q[rd_ptr_q];
  assign mem_req_byteen = byteen_q[rd_ptr_q];

  // Next-state for pointers, valid bits and occupancy.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (pop_fire) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_store) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({push_store, pop_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_store) begin
      addr_q[wr_ptr_q]   <= evict_addr;
      data_q[wr_ptr_q]   <= evict_data;
      byteen_q[wr_ptr_q] <= evict_byteen;
    end
  end

  always_comb begin
    lookup_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
        lookup_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_cache_evict_buf.sv
// Scoreboard bench for vx_cache_evict_buf: directed pushes queue expected
// requests; a negedge monitor compares every accepted memory request.
module tb_vx_cache_evict_buf;

  localparam int unsigned LS = 16;
  localparam int unsigned AW = 26;
  localparam int unsigned DP = 2;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [LS*8-1:0] data;
    logic [LS-1:0]   byteen;
  } req_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            evict_valid = 1'b0;
  logic [AW-1:0]   evict_addr = '0;
  logic [LS*8-1:0] evict_data = '0;
  logic [LS-1:0]   evict_byteen = '0;
  logic            evict_ready;
  logic            mem_req_valid;
  logic [AW-1:0]   mem_req_addr;
  logic [LS*8-1:0] mem_req_data;
  logic [LS-1:0]   mem_req_byteen;
  logic            mem_req_ready = 1'b0;
  logic [AW-1:0]   lookup_addr = '0;
  logic            lookup_hit;
  logic [1:0]      count;

  int n_pass = 0;
  int n_total = 0;
  req_t exp_q[$];

  vx_cache_evict_buf #(.LINE_SIZE(LS), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_byteen(evict_byteen), .evict_ready(evict_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
    .mem_req_ready(mem_req_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LS*8-1:0] mk_data(input logic [AW-1:0] a);
    return {4{32'hC0DE0000 ^ 32'(a)}};
  endfunction

  // Monitor: every request accepted at the coming edge is checked in order.
  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", 160'(mem_req_addr), 160'hDEAD);
      end else begin
        req_t e;
        req_t a;
        e = exp_q.pop_front();
        a = '{addr: mem_req_addr, data: mem_req_data, byteen: mem_req_byteen};
        check("req_addr", 160'(a.addr), 160'(e.addr));
        check("req_payload", 160'({a.data, a.byteen}), 160'({e.data, e.byteen}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one eviction and hold it until the handshake completes.
  task automatic push(input logic [AW-1:0] a, input logic [LS-1:0] be);
    int budget;
    evict_valid  = 1'b1;
    evict_addr   = a;
    evict_data   = mk_data(a);
    evict_byteen = be;
    budget = 50;
    while (!evict_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("push_timeout", 160'(evict_ready), 160'(1));
    if (be != '0) exp_q.push_back('{addr: a, data: mk_data(a), byteen: be});
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    mem_req_ready = 1'b1;
    budget = 50;
    while (count != 2'd0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 160'(count), 160'(0));
    mem_req_ready = 1'b0;
  endtask

  initial begin
    #12;
    reset = 1'b1;
    tick();
    check("rst_count", 160'(count), 160'(0));
    check("rst_evict_ready", 160'(evict_ready), 160'(1));
    check("rst_req_valid", 160'(mem_req_valid), 160'(0));
    check("rst_lookup", 160'(lookup_hit), 160'(0));

    // Single dirty line
    push(26'h100, 16'hFFFF);
    check("single_valid", 160'(mem_req_valid), 160'(1));
    check("single_count", 160'(count), 160'(1));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("single_drained_count", 160'(count), 160'(0));
    check("single_drained_valid", 160'(mem_req_valid), 160'(0));

    // Clean line is dropped
    push(26'h200, 16'h0000);
    lookup_addr = 26'h200;
    #1;
    check("clean_count", 160'(count), 160'(0));
    check("clean_valid", 160'(mem_req_valid), 160'(0));
    check("clean_lookup", 160'(lookup_hit), 160'(0));

    // Full and wrap
    push(26'hA, 16'h000F);
    push(26'hB, 16'h00FF);
    check("full_count", 160'(count), 160'(2));
    check("full_ready", 160'(evict_ready), 160'(0));
    evict_valid = 1'b1; evict_addr = 26'hC; evict_data = mk_data(26'hC); evict_byteen = 16'hF000;
    tick();
    check("stall_count", 160'(count), 160'(2));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("pop_from_full_count", 160'(count), 160'(1));
    check("pop_from_full_ready", 160'(evict_ready), 160'(1));
    exp_q.push_back('{addr: 26'hC, data: mk_data(26'hC), byteen: 16'hF000});
    tick();
    evict_valid = 1'b0;
    check("wrap_count", 160'(count), 160'(2));
    drain();

    // Simultaneous push and pop
    push(26'h10, 16'h1111);
    check("sim_pre_count", 160'(count), 160'(1));
    mem_req_ready = 1'b1;
    evict_valid = 1'b1; evict_addr = 26'h11; evict_data = mk_data(26'h11); evict_byteen = 16'h00F0;
    exp_q.push_back('{addr: 26'h11, data: mk_data(26'h11), byteen: 16'h00F0});
    tick();
    evict_valid = 1'b0;
    mem_req_ready = 1'b0;
    check("sim_count", 160'(count), 160'(1));
    check("sim_next_addr", 160'(mem_req_addr), 160'(26'h11));
    check("sim_next_byteen", 160'(mem_req_byteen), 160'(16'h00F0));
    drain();

    // Lookup
    push(26'h300, 16'h0001);
    push(26'h301, 16'h8000);
    lookup_addr = 26'h301; #1;
    check("lookup_301_hit", 160'(lookup_hit), 160'(1));
    lookup_addr = 26'h302; #1;
    check("lookup_302_miss", 160'(lookup_hit), 160'(0));
    drain();
    lookup_addr = 26'h301; #1;
    check("lookup_301_after_pop", 160'(lookup_hit), 160'(0));

    // Async reset mid-operation
    push(26'h500, 16'h00FF);
    push(26'h501, 16'hFF00);
    check("prereset_count", 160'(count), 160'(2));
    lookup_addr = 26'h500;
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("areset_valid", 160'(mem_req_valid), 160'(0));
    check("areset_count", 160'(count), 160'(0));
    check("areset_ready", 160'(evict_ready), 160'(1));
    check("areset_lookup", 160'(lookup_hit), 160'(0));
    #1;
    reset = 1'b1;
    tick();
    push(26'h400, 16'h0F0F);
    check("post_reset_count", 160'(count), 160'(1));
    drain();

    tick();
    check("scoreboard_empty", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vx_cache_evict_buf.md
# vx_cache_evict_buf

Writeback eviction buffer sitting directly downstream of the cache bank data store. It captures evicted lines (line data plus per-byte dirty mask) as they emerge from the data/byteen RAM read port on fill or flush, holds them in a small FIFO, and issues them as memory write requests under a valid/ready handshake. It also provides an address lookup so the bank can hold a miss whose line is still pending writeback.

## Interface
- LINE_SIZE, 16, line size in bytes; line data width is LINE_SIZE*8.
- ADDR_WIDTH, 26, line-address width.
- DEPTH, 2, number of buffer entries; a power of two, at least 2.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- evict_valid  in  1  evicted line presented.
- evict_addr  in  ADDR_WIDTH  line address of the evicted line.
- evict_data  in  LINE_SIZE*8  line data from the data store read port.
- evict_byteen  in  LINE_SIZE  dirty-byte mask from the byteen store (all ones when dirty bytes are disabled).
- evict_ready  out  1  buffer can accept.
- mem_req_valid  out  1  write request valid.
- mem_req_addr  out  ADDR_WIDTH  request line address.
- mem_req_data  out  LINE_SIZE*8  request data.
- mem_req_byteen  out  LINE_SIZE  request byte enables.
- mem_req_ready  in  1  memory accepts request.
- lookup_addr  in  ADDR_WIDTH  miss address to check.
- lookup_hit  out  1  some valid entry holds lookup_addr.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: circular FIFO of DEPTH entries {addr, data, byteen} with per-entry valid bit; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: on evict_valid && evict_ready. If evict_byteen is nonzero, the entry is written at wr_ptr, its valid bit is set, and wr_ptr increments. If evict_byteen == 0 (clean line), the handshake completes and nothing is stored.
- evict_ready = (count != DEPTH). It is independent of mem_req_ready: no pass-through while full, so a pop and a push never land in the same slot.
- Pop: on mem_req_valid && mem_req_ready; the entry at rd_ptr is cleared and rd_ptr increments.
- mem_req_* are driven from the entry at rd_ptr. mem_req_valid = (count != 0).
- Once mem_req_valid is asserted, the mem_req_* fields stay stable until the request is accepted.
- Simultaneous push (stored) and pop: count is unchanged and both pointers advance.
- lookup_hit: combinational OR over valid entries of (entry.addr == lookup_addr). It does not include the entry being pushed in the same cycle; the bank evaluates lookups one cycle after the evict.
- Duplicate addresses may coexist. Memory ordering is preserved by FIFO order.

## Timing
- Reset (reset=0, asynchronous): count=0, pointers=0, all valid bits=0. This gives mem_req_valid=0, evict_ready=1 and lookup_hit=0. mem_req_addr/data/byteen are don't-care while invalid.
- Reset asserted mid-transfer discards every entry immediately, with no request completion. Deassertion is synchronized by the surrounding reset tree.
- Latency: a line accepted in cycle N appears on mem_req_valid in cycle N+1 when the buffer was empty.
- Throughput: one push and one pop per cycle.
- evict_ready falls in the cycle after the push that fills the buffer. It rises in the cycle after a pop from full.
- count updates one cycle after each handshake.

## Test plan
- Reset and single dirty line: with mem_req_ready=0, push addr=0x100 and byteen=0xFFFF. Next cycle: mem_req_valid=1, addr=0x100, count=1. Raise mem_req_ready; one cycle later count=0 and mem_req_valid=0.
- Clean line drop: push byteen=0x0000 at addr=0x200. Required: evict_ready handshake completes, count stays 0, no mem request, and lookup_hit for 0x200 is 0.
- Full and wrap: DEPTH=2, mem_req_ready=0. Push 0xA, 0xB; then evict_ready=0 and the 0xC push stalls. Release one pop (0xA issued), after which 0xC is accepted. Required issue order: 0xA, 0xB, 0xC, with the pointers wrapped.
- Simultaneous push/pop: count=1 (0x10 stored). In the same cycle pop 0x10 and push 0x11 with byteen=0x00F0. Required: count stays 1, and the next request is addr 0x11 with byteen 0x00F0.
- Lookup: store 0x300 and 0x301. lookup_addr=0x301 gives lookup_hit=1; 0x302 gives 0. After both pops, 0x301 gives 0.
- Async reset mid-operation: with 2 entries held and mem_req_ready=0, pulse reset low between clock edges. Required: mem_req_valid=0 and count=0 immediately, before the next edge; after release the buffer accepts a new push normally.
